// File: rtl/lamp_switch_conditioner_pkg.sv
// Shared definitions for the lamp switch conditioner: turn FSM state codes
// and the decode used whenever the FSM chooses a direction from a clean start.
package lamp_switch_conditioner_pkg;

  localparam int TURN_STATE_W = 3;

  typedef enum logic [TURN_STATE_W-1:0] {
    IDLE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    HAZARD = 3'd3,
    GAP    = 3'd4
  } turnState_e;

  // Direction chosen from a blank lamp: {left, right} request to state.
  function automatic turnState_e idleDecode(input logic [1:0] req);
    turnState_e result;
    case (req)
      2'b00:   result = IDLE;
      2'b10:   result = LEFT;
      2'b01:   result = RIGHT;
      default: result = HAZARD;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Synchroniser plus debouncer for one raw dashboard switch. The clean level
// only moves after the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive edges.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser with nothing between the flops, to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count edges of disagreement; any return to the held level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lamp_switch_conditioner.sv
// Front end of the car lamp controller: debounces the four dashboard switches
// and sequences the turn requests so every direction swap passes through a
// dark gap before the new direction is presented downstream.
module lamp_switch_conditioner
  import lamp_switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int GAP_CYCLES      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_left,
  input  logic                    sw_right,
  input  logic                    sw_brake,
  input  logic                    sw_door,
  output logic                    rstL,
  output logic                    rstR,
  output logic                    rstBrake,
  output logic                    rstDoor,
  output logic [TURN_STATE_W-1:0] turn_state
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic dbLeft;
  logic dbRight;
  logic dbBrake;
  logic dbDoor;
  logic [1:0] req;

  turnState_e state;
  turnState_e nextState;
  logic [GAP_W-1:0] gcnt;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) leftDebounce (
    .clk(clk), .rst(rst), .raw(sw_left), .db(dbLeft)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) rightDebounce (
    .clk(clk), .rst(rst), .raw(sw_right), .db(dbRight)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) brakeDebounce (
    .clk(clk), .rst(rst), .raw(sw_brake), .db(dbBrake)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) doorDebounce (
    .clk(clk), .rst(rst), .raw(sw_door), .db(dbDoor)
  );

  assign req = {dbLeft, dbRight};

  // Next turn state: a direction change that would leave one lamp lit goes through GAP.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = idleDecode(req);
      LEFT: begin
        case (req)
          2'b10:   nextState = LEFT;
          2'b00:   nextState = IDLE;
          2'b11:   nextState = HAZARD;
          default: nextState = GAP;
        endcase
      end
      RIGHT: begin
        case (req)
          2'b01:   nextState = RIGHT;
          2'b00:   nextState = IDLE;
          2'b11:   nextState = HAZARD;
          default: nextState = GAP;
        endcase
      end
      HAZARD: begin
        case (req)
          2'b11:   nextState = HAZARD;
          2'b00:   nextState = IDLE;
          default: nextState = GAP;
        endcase
      end
      GAP: begin
        if (gcnt == GAP_LAST) begin
          nextState = idleDecode(req);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State, gap timer and turn outputs registered together so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gcnt  <= '0;
      rstL  <= 1'b0;
      rstR  <= 1'b0;
    end else begin
      state <= nextState;
      if (state == GAP && nextState == GAP) begin
        gcnt <= gcnt + 1'b1;
      end else begin
        gcnt <= '0;
      end
      rstL <= (nextState == LEFT) || (nextState == HAZARD);
      rstR <= (nextState == RIGHT) || (nextState == HAZARD);
    end
  end

  // Brake and door get one register so they line up with the turn outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstBrake <= 1'b0;
      rstDoor  <= 1'b0;
    end else begin
      rstBrake <= dbBrake;
      rstDoor  <= dbDoor;
    end
  end

  assign turn_state = state;

endmodule
